// File: rtl/hazard_controller.sv
// Pipeline hazard/sequencing controller: load-use stalls, taken-branch squash, halt/drain.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush performance counters.
module hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instruction,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt_addr,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] DRAIN_RELOAD = 4'(DRAIN_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_uses_rt;
    logic        w_hazard;
    logic        w_halt_word;

    assign w_op        = id_instruction[31:26];
    assign w_rs        = id_instruction[25:21];
    assign w_rt        = id_instruction[20:16];
    assign w_uses_rt   = (w_op == 6'h00) || (w_op == 6'h04) ||
                         (w_op == 6'h05) || (w_op == 6'h2B);
    assign w_hazard    = ex_mem_read && (ex_rt_addr != 5'd0) &&
                         ((ex_rt_addr == w_rs) || (w_uses_rt && (ex_rt_addr == w_rt)));
    assign w_halt_word = (id_instruction == 32'hFFFF_FFFF);

    // Outputs are combinational; reset forces a full freeze-and-flush of the front end.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_hazard || w_halt_word) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                default: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            endcase
        end
    end

    assign halted = rst_n && (r_state == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // A taken branch squashes the ID instruction, so its hazard/halt is moot.
                    if (!branch_taken) begin
                        if (w_hazard) begin
                            if (LOAD_STALL_CYCLES > 1) begin
                                r_state <= S_STALL;
                                r_cnt   <= STALL_RELOAD;
                            end
                        end else if (w_halt_word) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= DRAIN_RELOAD;
                        end
                    end
                end
                S_STALL: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_RUN;
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_HALTED;
                end
                default: r_state <= S_HALTED;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic        w_stall_inc;

    assign w_stall_inc = !pc_write && ((r_state == S_RUN) || (r_state == S_STALL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (w_stall_inc && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (ifid_flush && (r_flush_count != 32'hFFFF_FFFF))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: default instance (a) and a 3-bubble instance (b)
// share stimulus; each scenario starts from reset and checks only the instance it targets.
module tb_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] I_RTYPE = 32'h002A000A; // rs=1 rt=10
    localparam logic [31:0] I_ADDI  = 32'h202A0005; // addi rs=1 rt=10 (rt not a source)
    localparam logic [31:0] I_ADDRS = 32'h21430000; // addi rs=10
    localparam logic [31:0] I_HALT  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_instruction = '0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt_addr = '0;
    logic        branch_taken = 1'b0;

    logic        a_pcw, a_ifw, a_iff, a_idf, a_halt;
    logic [31:0] a_sc, a_fc;
    logic        b_pcw, b_ifw, b_iff, b_idf, b_halt;
    logic [31:0] b_sc, b_fc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_controller u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_instruction(id_instruction),
        .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr), .branch_taken(branch_taken),
        .pc_write(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_iff), .idex_flush(a_idf),
        .halted(a_halt), .stall_cycles(a_sc), .flush_count(a_fc)
    );

    hazard_controller #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_instruction(id_instruction),
        .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr), .branch_taken(branch_taken),
        .pc_write(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_iff), .idex_flush(b_idf),
        .halted(b_halt), .stall_cycles(b_sc), .flush_count(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // New inputs at the falling edge; outputs settle 1ns later, well before the rising edge.
    task automatic cyc(input logic [31:0] ins, input logic mr, input logic [4:0] rt, input logic bt);
        @(negedge clk);
        id_instruction = ins;
        ex_mem_read    = mr;
        ex_rt_addr     = rt;
        branch_taken   = bt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        id_instruction = '0; ex_mem_read = 1'b0; ex_rt_addr = '0; branch_taken = 1'b0;
        #1;
        chk("rst_pcw", a_pcw, 1'b0);
        chk("rst_ifw", a_ifw, 1'b0);
        chk("rst_iff", a_iff, 1'b1);
        chk("rst_idf", a_idf, 1'b1);
        chk("rst_halt", a_halt, 1'b0);
        chk("rst_cnts", a_sc | a_fc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Asynchronous pulse between edges; outputs must react without any clock.
    task automatic async_reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_a_halt", a_halt, 1'b0);
        chk("arst_a_pcw", a_pcw, 1'b0);
        chk("arst_b_pcw", b_pcw, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Load-use, single bubble
        do_reset();
        cyc(I_RTYPE, 1'b1, 5'd10, 1'b0);
        chk("lu_pcw", a_pcw, 1'b0);
        chk("lu_ifw", a_ifw, 1'b0);
        chk("lu_idf", a_idf, 1'b1);
        chk("lu_iff", a_iff, 1'b0);
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("lu_after_pcw", a_pcw, 1'b1);
        chk("lu_sc", a_sc, PERF ? 32'd1 : 32'd0);

        // No false hazards, then a true rs hazard on an I-type
        cyc(32'h0, 1'b1, 5'd0, 1'b0);
        chk("nf_r0_pcw", a_pcw, 1'b1);
        cyc(I_ADDI, 1'b1, 5'd10, 1'b0);
        chk("nf_addi_pcw", a_pcw, 1'b1);
        cyc(I_ADDRS, 1'b1, 5'd10, 1'b0);
        chk("rs_haz_pcw", a_pcw, 1'b0);
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("rs_haz_sc", a_sc, PERF ? 32'd2 : 32'd0);
        chk("rs_haz_fc", a_fc, 32'd0);

        // Three-bubble instance, branch during stall ignored
        do_reset();
        cyc(I_RTYPE, 1'b1, 5'd10, 1'b0);
        chk("ls3_c1_pcw", b_pcw, 1'b0);
        cyc(32'h0, 1'b0, 5'd0, 1'b1);
        chk("ls3_c2_pcw", b_pcw, 1'b0);
        chk("ls3_c2_iff", b_iff, 1'b0);
        chk("ls3_c2_idf", b_idf, 1'b1);
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("ls3_c3_pcw", b_pcw, 1'b0);
        chk("ls3_c3_ifw", b_ifw, 1'b0);
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("ls3_c4_pcw", b_pcw, 1'b1);
        chk("ls3_sc", b_sc, PERF ? 32'd3 : 32'd0);
        chk("ls3_fc", b_fc, 32'd0);
        // Reset mid-stall aborts the sequence
        cyc(I_RTYPE, 1'b1, 5'd10, 1'b0);
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("ls3_mid_pcw", b_pcw, 1'b0);
        async_reset_pulse();
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("ls3_abort_pcw", b_pcw, 1'b1);
        chk("ls3_abort_sc", b_sc, 32'd0);

        // Branch and hazard together: branch wins; halt word under branch is squashed
        do_reset();
        cyc(I_RTYPE, 1'b1, 5'd10, 1'b1);
        chk("bh_iff", a_iff, 1'b1);
        chk("bh_idf", a_idf, 1'b1);
        chk("bh_pcw", a_pcw, 1'b1);
        chk("bh_ifw", a_ifw, 1'b1);
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("bh_run_pcw", a_pcw, 1'b1);
        chk("bh_fc", a_fc, PERF ? 32'd1 : 32'd0);
        chk("bh_sc", a_sc, 32'd0);
        cyc(I_HALT, 1'b0, 5'd0, 1'b1);
        chk("bhalt_pcw", a_pcw, 1'b1);
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("bhalt_run_pcw", a_pcw, 1'b1);
        chk("bhalt_fc", a_fc, PERF ? 32'd2 : 32'd0);

        // Halt and drain (4 drain cycles)
        do_reset();
        cyc(I_HALT, 1'b0, 5'd0, 1'b0);
        chk("hlt_det_pcw", a_pcw, 1'b0);
        chk("hlt_det_idf", a_idf, 1'b1);
        chk("hlt_det_halt", a_halt, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(I_RTYPE, 1'b1, 5'd10, i[0]);
            chk($sformatf("drain%0d_halt", i), a_halt, 1'b0);
            chk($sformatf("drain%0d_pcw", i), a_pcw, 1'b0);
            chk($sformatf("drain%0d_iff", i), a_iff, 1'b0);
            chk($sformatf("drain%0d_idf", i), a_idf, 1'b1);
        end
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("hlt_rise", a_halt, 1'b1);
        cyc(I_RTYPE, 1'b1, 5'd10, 1'b1);
        chk("hlt_sticky1", a_halt, 1'b1);
        chk("hlt_sticky_pcw", a_pcw, 1'b0);
        cyc(32'h0, 1'b0, 5'd0, 1'b1);
        chk("hlt_sticky2", a_halt, 1'b1);
        chk("hlt_sc", a_sc, PERF ? 32'd1 : 32'd0);
        chk("hlt_fc", a_fc, 32'd0);
        async_reset_pulse();
        cyc(32'h0, 1'b0, 5'd0, 1'b0);
        chk("hlt_clr_halt", a_halt, 1'b0);
        chk("hlt_clr_pcw", a_pcw, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage MIPS core. It watches the instruction in ID and the load/branch status of EX, and drives the PC and IF/ID write enables and the IF/ID and ID/EX flushes. It covers load-use stalls, taken-branch squashes and the halt/drain sequence, and optionally keeps stall and flush performance counters. It sits beside `instruction_decode` and gates the fetch and decode pipeline registers.

## Interface
Parameters:
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard. Legal range is 1..3.
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN after a halt before `halted` asserts. Legal range is 1..15.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `id_instruction`  in  32: instruction currently in ID.
- `ex_mem_read`  in  1: the EX-stage instruction is a load.
- `ex_rt_addr`  in  5: destination register of the EX-stage load.
- `branch_taken`  in  1: the branch in EX resolved taken this cycle.
- `pc_write`  out  1: PC register enable.
- `ifid_write`  out  1: IF/ID register enable.
- `ifid_flush`  out  1: load a NOP into IF/ID.
- `idex_flush`  out  1: load a bubble into ID/EX.
- `halted`  out  1: sticky, core stopped.
- `stall_cycles`  out  32: count of cycles with `pc_write`=0, saturating.
- `flush_count`  out  32: count of `ifid_flush` pulses, saturating.

## Operation
- FSM states are RUN, STALL, DRAIN and HALTED. Registers are the state, a 4-bit counter `cnt`, and the two performance counters.
- Fields: `rs`=[25:21], `rt`=[20:16], `op`=[31:26].
- The ID instruction uses `rt` when `op` ∈ {0x00, 0x04, 0x05, 0x2B}.
- Hazard condition: `ex_mem_read` & `ex_rt_addr`≠0 & (`ex_rt_addr`==`rs` | (uses `rt` & `ex_rt_addr`==`rt`)).
- The halt word is `id_instruction`==32'hFFFFFFFF.

RUN defaults: `pc_write`=1, `ifid_write`=1, both flushes 0. Events are resolved in this priority order:
1. `branch_taken` drives `ifid_flush`=1 and `idex_flush`=1. The state stays RUN. Any hazard or halt word in ID is ignored, because that instruction is squashed.
2. Hazard drives `pc_write`=0, `ifid_write`=0 and `idex_flush`=1.
   - If `LOAD_STALL_CYCLES`>1, go to STALL with `cnt`=`LOAD_STALL_CYCLES`-1.
   - Otherwise stay in RUN.
3. Halt word drives `pc_write`=0, `ifid_write`=0 and `idex_flush`=1, then goes to DRAIN with `cnt`=`DRAIN_CYCLES`.

STALL:
- Outputs are the same as the hazard case in RUN.
- `cnt` decrements each cycle. When `cnt`==1, go to RUN.
- `branch_taken` is ignored here, because EX holds a bubble.

DRAIN:
- Outputs: `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `idex_flush`=1.
- `cnt` decrements each cycle. When `cnt`==1, go to HALTED.
- All inputs are ignored.

HALTED:
- Outputs are the same as DRAIN, plus `halted`=1.
- The state is terminal until `rst_n` asserts.

Performance counters:
- `stall_cycles` increments on every clock edge where `pc_write`==0 and the state is RUN or STALL.
- `flush_count` increments on every clock edge where `ifid_flush`==1.
- Both saturate at 32'hFFFFFFFF.

## Timing
- All outputs are combinational from the current state and the current-cycle inputs. State and counters update on the rising edge of `clk`.
- While `rst_n`=0, and immediately on its assertion: state=RUN, `cnt`=0, `halted`=0, counters=0, `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_flush`=1.
- On the first edge after deassertion, normal RUN behaviour applies.
- A load-use hazard yields exactly `LOAD_STALL_CYCLES` consecutive cycles of `pc_write`=0.
- From the halt-detect cycle, `halted` rises after exactly `DRAIN_CYCLES`+1 cycles, which includes the detect cycle.
- Reset asserted mid-STALL or mid-DRAIN aborts the sequence immediately.
- When `branch_taken` and a hazard occur in the same cycle, the branch wins and no stall is counted.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cycles` and `flush_count` are implemented as described above.
- `HAZARD_PERF_CNT_EN` undefined: no counter flops exist, and both outputs are constant 32'd0.
- FSM behaviour is identical in both builds.

## Test plan
- Load-use, default parameters.
  - Stimulus: `ex_mem_read`=1, `ex_rt_addr`=10, `id_instruction`=32'h002A000A (R-type, `rt`=10).
  - Response: one cycle of `pc_write`=0, `ifid_write`=0, `idex_flush`=1, then RUN. `stall_cycles`=1.
- No false hazard.
  - Case 1: `ex_rt_addr`=0 with `rs`=0.
  - Case 2: `ex_rt_addr`=10 with an `addi` (op 0x08) whose `rt` field is 10.
  - Response in both cases: `pc_write` stays 1.
- `LOAD_STALL_CYCLES`=3 hazard.
  - Response: exactly 3 stall cycles. `branch_taken`=1 pulsed during the stall is ignored, and `flush_count` stays 0.
- Branch and hazard in the same cycle.
  - Response: `ifid_flush`=1, `idex_flush`=1, `pc_write`=1, `flush_count`=1, state RUN.
- Halt with `DRAIN_CYCLES`=4.
  - Stimulus: `id_instruction`=32'hFFFFFFFF.
  - Response: `halted` rises 5 cycles later and stays high under arbitrary inputs. An asynchronous `rst_n` pulse clears it immediately.
- Build without `HAZARD_PERF_CNT_EN`.
  - Response: after repeating the load-use scenario, both counters read 0.
